// File: rtl/fe_req_sched.sv
// Round-robin scheduler sharing the HPS front-end service channel between
// device models. Offers one request at a time through a CLAIM/DONE register
// handshake, raises irq while an offer is pending, and holds a completed
// device off for HOLDOFF cycles so its request level has time to drop.
module fe_req_sched #(
    parameter int NREQ    = 32,
    parameter int HOLDOFF = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      avs_address,
    input  logic            avs_read,
    input  logic            avs_write,
    input  logic [31:0]     avs_writedata,
    output logic [31:0]     avs_readdata,
    output logic            avs_readdatavalid,
    output logic            irq,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, OFFER, SERVE} state_t;

    localparam logic [1:0] ADDR_CLAIM  = 2'd0;
    localparam logic [1:0] ADDR_DONE   = 2'd1;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    state_t          state;
    logic [4:0]      cur;
    logic [4:0]      last;
    logic [NREQ-1:0] mask;
    logic [7:0]      hold_cnt [NREQ];
    logic [NREQ-1:0] hold;
    logic [NREQ-1:0] elig;
    logic [31:0]     req_ext;
    logic [31:0]     mask_ext;
    logic [31:0]     elig_ext;
    logic [31:0]     rd_mux;
    logic            pick_vld;
    logic [4:0]      pick;
    int              idx;
    logic            wr_en;
    logic            claim;
    logic            withdraw;
    logic            done_hit;

    // Holdoff flags and eligibility; vectors are widened to 32 bits so a
    // 5-bit id can index them for any NREQ.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            hold[i] = (hold_cnt[i] != 8'd0);
        end
        elig     = req & ~mask & ~hold;
        req_ext  = '0;
        mask_ext = '0;
        elig_ext = '0;
        req_ext[NREQ-1:0]  = req;
        mask_ext[NREQ-1:0] = mask;
        elig_ext[NREQ-1:0] = elig;
    end

    // Round-robin pick: first eligible id searching upward from last+1.
    // Scanning from the far end lets the nearest candidate overwrite the rest.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(last) + 1 + k) % NREQ;
            if (elig_ext[idx[4:0]]) begin
                pick_vld = 1'b1;
                pick     = idx[4:0];
            end
        end
    end

    // Bus decode; a write in the same cycle as a read is dropped.
    always_comb begin
        wr_en    = avs_write & ~avs_read;
        claim    = avs_read && (avs_address == ADDR_CLAIM) && (state == OFFER);
        withdraw = ~req_ext[cur] | mask_ext[cur];
        done_hit = wr_en && (avs_address == ADDR_DONE) && (state == SERVE)
                   && (avs_writedata[4:0] == cur);
        case (avs_address)
            ADDR_CLAIM:  rd_mux = (state == OFFER) ? {1'b1, 26'd0, cur} : 32'd0;
            ADDR_MASK:   rd_mux = mask_ext;
            ADDR_STATUS: rd_mux = req_ext;
            default:     rd_mux = 32'd0;
        endcase
    end

    // Offer/serve state machine with registered irq/busy and bus registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            cur               <= '0;
            last              <= 5'(NREQ - 1);
            mask              <= '0;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            irq               <= 1'b0;
            busy              <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
            if (wr_en && (avs_address == ADDR_MASK)) begin
                mask <= avs_writedata[NREQ-1:0];
            end
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        cur   <= pick;
                        state <= OFFER;
                        irq   <= 1'b1;
                    end
                end
                OFFER: begin
                    if (claim) begin
                        last  <= cur;
                        state <= SERVE;
                        irq   <= 1'b0;
                        busy  <= 1'b1;
                    end else if (withdraw) begin
                        state <= IDLE;
                        irq   <= 1'b0;
                    end
                end
                SERVE: begin
                    if (done_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Per-device holdoff counters: loaded on a matching DONE, then count to 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREQ; i++) begin
                hold_cnt[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (done_hit && (int'(cur) == i)) begin
                    hold_cnt[i] <= 8'(HOLDOFF);
                end else if (hold_cnt[i] != 8'd0) begin
                    hold_cnt[i] <= hold_cnt[i] - 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fe_req_sched.sv
// Directed bench for fe_req_sched with NREQ=3, HOLDOFF=4. Inputs change on
// the falling edge; outputs are observed on the falling edge.
module tb_fe_req_sched;

    localparam int NREQ    = 3;
    localparam int HOLDOFF = 4;

    logic            clk;
    logic            reset_n;
    logic [NREQ-1:0] req;
    logic [1:0]      avs_address;
    logic            avs_read;
    logic            avs_write;
    logic [31:0]     avs_writedata;
    logic [31:0]     avs_readdata;
    logic            avs_readdatavalid;
    logic            irq;
    logic            busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] rdata;

    fe_req_sched #(.NREQ(NREQ), .HOLDOFF(HOLDOFF)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req               (req),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .irq               (irq),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic wait_irq(input string tag);
        int n;
        n = 0;
        while (!irq && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, irq}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; req = '0; avs_address = '0;
        avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        tick(3);
        chk("rst_irq",  {31'd0, irq}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdv",  {31'd0, avs_readdatavalid}, 32'd0);
        chk("rst_data", avs_readdata, 32'd0);
        reset_n = 1'b1;
        tick(2);
        chk("idle_irq", {31'd0, irq}, 32'd0);

        // Single request and holdoff
        req = 3'b001;
        tick(1);
        chk("single_irq", {31'd0, irq}, 32'd1);
        rd(2'd0, rdata);
        chk("single_claim", rdata, 32'h8000_0000);
        chk("single_busy", {31'd0, busy}, 32'd1);
        chk("single_irq_fall", {31'd0, irq}, 32'd0);
        wr(2'd1, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < HOLDOFF; i++) begin
            tick(1);
            chk("holdoff_irq_low", {31'd0, irq}, 32'd0);
        end
        tick(1);
        chk("holdoff_irq_back", {31'd0, irq}, 32'd1);

        // Fairness over all three devices
        req = 3'b111;
        for (int n = 0; n < 6; n++) begin
            wait_irq("fair_irq");
            rd(2'd0, rdata);
            chk("fair_claim", rdata, 32'h8000_0000 | 32'(n % 3));
            wr(2'd1, 32'(n % 3));
        end
        req = 3'b000;
        tick(6);
        chk("quiet_irq", {31'd0, irq}, 32'd0);

        // Withdrawal of a pending offer
        req = 3'b100;
        wait_irq("wd_irq");
        req = 3'b000;
        tick(1);
        chk("wd_irq_fall", {31'd0, irq}, 32'd0);
        rd(2'd0, rdata);
        chk("wd_claim_zero", rdata, 32'd0);
        chk("wd_busy", {31'd0, busy}, 32'd0);
        req = 3'b010;
        wait_irq("wd_next_irq");
        rd(2'd0, rdata);
        chk("wd_next_claim", rdata, 32'h8000_0001);

        // Bad DONE, then mask device 1 and complete it
        wr(2'd1, 32'd2);
        chk("bad_done_busy", {31'd0, busy}, 32'd1);
        wr(2'd2, 32'd2);
        rd(2'd2, rdata);
        chk("mask_read", rdata, 32'd2);
        wr(2'd1, 32'd1);
        chk("masked_done_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("masked_irq", {31'd0, irq}, 32'd0);
        end
        rd(2'd3, rdata);
        chk("status_masked", rdata, 32'd2);
        rd(2'd1, rdata);
        chk("done_reads_zero", rdata, 32'd0);

        // Reset in the middle of service
        wr(2'd2, 32'd0);
        wait_irq("unmask_irq");
        rd(2'd0, rdata);
        chk("unmask_claim", rdata, 32'h8000_0001);
        wr(2'd2, 32'd4);
        req = 3'b011;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_irq",  {31'd0, irq}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_data", avs_readdata, 32'd0);
        chk("midrst_rdv",  {31'd0, avs_readdatavalid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(1);
        chk("postrst_irq", {31'd0, irq}, 32'd1);
        rd(2'd2, rdata);
        chk("postrst_mask", rdata, 32'd0);
        rd(2'd0, rdata);
        chk("postrst_claim", rdata, 32'h8000_0000);

        // Read latency on STATUS
        req = 3'b101;
        tick(1);
        chk("rdv_idle", {31'd0, avs_readdatavalid}, 32'd0);
        avs_address = 2'd3;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        chk("rdv_pulse", {31'd0, avs_readdatavalid}, 32'd1);
        chk("status_data", avs_readdata, 32'd5);
        @(negedge clk);
        chk("rdv_drop", {31'd0, avs_readdatavalid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fe_req_sched.md
# fe_req_sched

Round-robin scheduler that shares the single HPS front-end service channel between the FPGA device models (paper-tape reader, paper-tape punch, 340 display, and future units) that raise data requests. It sits between the per-device `*_fe_data_rq` level signals and the HPS lightweight Avalon bus. It offers one request at a time to HPS software through a claim/done handshake, raises an interrupt while an offer is pending, and masks a serviced device briefly so that its request level can drop.

## Interface
- `NREQ`, default 32: number of request inputs, 1..32.
- `HOLDOFF`, default 16: cycles a completed device stays masked after DONE; valid range 1..255.
- `clk` in 1: 50 MHz system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in NREQ: level requests from the devices. Bit i is device id i.
- `avs_address` in 2: register select.
- `avs_read` in 1: Avalon read strobe.
- `avs_write` in 1: Avalon write strobe.
- `avs_writedata` in 32: write data.
- `avs_readdata` out 32: read data, registered.
- `avs_readdatavalid` out 1: pulses once, one cycle after `avs_read`.
- `irq` out 1: high while an offer is pending.
- `busy` out 1: high while a request is in service (for panel LED).

## Operation
- Registers:
  - 0 CLAIM (R): bit31 = offer valid, bits 4:0 = offered id. Reading with valid=1 claims the offer, as a side effect.
  - 1 DONE (W): bits 4:0 = id being completed.
  - 2 MASK (R/W): bit i = 1 disables device i. Resets to 0.
  - 3 STATUS (R): bits NREQ-1:0 = raw `req`. No side effect.
- Eligible vector: `elig = req & ~MASK & ~hold`. Here `hold` bit i is set while device i's holdoff counter is nonzero.
- Round-robin pointer `last` resets to NREQ-1. The pick is the first set bit of `elig` searching upward from `last+1`, wrapping modulo NREQ.
- States:
  - IDLE: if `elig` is nonzero, latch the pick into `cur` and go to OFFER.
  - OFFER: `irq`=1. A CLAIM read returns {1,cur}, sets `last`=cur, and goes to SERVE. If `req[cur]` drops or MASK[cur] is set before the claim, withdraw the offer and return to IDLE; `last` is unchanged.
  - SERVE: `busy`=1. A DONE write with id==cur loads hold counter[cur]=HOLDOFF and goes to IDLE. A DONE write with any other id is ignored.
- CLAIM read outside OFFER returns 0 and has no effect.
- Writes to DONE outside SERVE are ignored.
- Writes to MASK take effect in the next cycle, in every state. Masking `cur` during SERVE does not abort service.
- Hold counters decrement by 1 per cycle and saturate at 0.
- Unused address bits, unused data bits, and request ids ≥NREQ read 0.
- Reset, including mid-operation: state=IDLE, `cur`=0, `last`=NREQ-1, MASK=0, all hold counters=0, `avs_readdata`=0, `avs_readdatavalid`=0, `irq`=0, `busy`=0. An in-flight claim is lost; software must re-read CLAIM.

## Timing
- `req` is assumed synchronous to `clk`; device models run in the same domain.
- IDLE→OFFER takes 1 cycle after `elig` becomes nonzero. `irq` is registered and rises on the same edge the state enters OFFER.
- Read latency is 1: `avs_readdata` and `avs_readdatavalid` are valid in the cycle after the `avs_read` cycle. There is no waitrequest.
- For CLAIM, the read data is sampled from the state and `cur` at the `avs_read` edge. On that same edge the state moves to SERVE, and `irq` falls on that edge.
- Simultaneous claim read and withdrawal condition in the same cycle: the claim wins, with valid data and state SERVE.
- Simultaneous read and write in one cycle is not supported; the write is ignored.
- DONE→IDLE takes 1 cycle. The earliest next offer appears 2 cycles after the DONE write.
- A device whose `req` is still high after HOLDOFF cycles is eligible again.

## Test plan
- Single request, NREQ=3, HOLDOFF=4: raise `req`=3'b001. Then `irq`=1 after 1 cycle, and a CLAIM read returns 0x8000_0000 with `busy`=1. Write DONE=0 and keep `req` high. `irq` must stay 0 for 4 cycles, then re-assert.
- Fairness: hold `req`=3'b111 and run the claim/done loop 6 times. The claimed ids must be 0,1,2,0,1,2.
- Withdrawal: raise `req[2]`, wait for OFFER, then drop `req[2]` before the read. `irq` must fall and CLAIM must read 0. Then raise `req[1]`; the next claim must return id 1.
- Bad DONE and MASK: while in SERVE with cur=1, write DONE=2. The state stays SERVE. Write MASK=0x2, then DONE=1. Device 1 must not be offered again while masked, and STATUS must still show `req`.
- Reset mid-service: assert `reset_n`=0 during SERVE. `irq`, `busy`, MASK, and `avs_readdata` must be 0 immediately, without waiting for a clock edge. After release with `req[0]` high, the first offer must be id 0.
- Read timing: issue a STATUS read with `req`=3'b101. `avs_readdatavalid` must be high exactly one cycle later, with data 0x0000_0005.
